// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 size
// encodings, trap cause codes and the LSU state type.
package mem_lsu_pkg;

  // funct3 size/sign encodings of RV32 loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Exception cause codes raised by the LSU
  localparam logic [3:0] TRAP_LD_MISALIGN = 4'd4;
  localparam logic [3:0] TRAP_LD_FAULT    = 4'd5;
  localparam logic [3:0] TRAP_ST_MISALIGN = 4'd6;
  localparam logic [3:0] TRAP_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU.
//   Store side: i_st_funct3/i_st_off/i_st_wdata -> o_st_data (replicated
//               lanes), o_st_sel (byte enables), o_misalign.
//   Load side:  i_ld_funct3/i_ld_off/i_ld_word  -> o_ld_data (lane picked by
//               offset, sign- or zero-extended).
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_sel,
  output logic        o_misalign,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_data  = i_st_wdata;
    o_st_sel   = 4'b1111;
    o_misalign = |i_st_off;
    case (i_st_funct3)
      F3_B, F3_BU: begin
        o_st_data  = {4{i_st_wdata[7:0]}};
        o_st_sel   = 4'b0001 << i_st_off;
        o_misalign = 1'b0;
      end
      F3_H, F3_HU: begin
        o_st_data  = {2{i_st_wdata[15:0]}};
        o_st_sel   = 4'b0011 << i_st_off;
        o_misalign = i_st_off[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_ld_word[7:0];
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase
    w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

    o_ld_data = i_ld_word;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit with a Wishbone classic data master.
//   Pipeline side: req_valid_i, is_store_i, funct3_i, addr_i, wdata_i, kill_i
//                  in; rdata_o, stall_o, trap_o/trap_code_o/badaddr_o out.
//   Bus side:      dwbm_addr_o/dat_o/sel_o/we_o/cyc_o/stb_o out;
//                  dwbm_dat_i/ack_i/err_i in.
//   BUS_TIMEOUT:   BUSY cycles allowed before a forced access fault (0 = off).
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        kill_i,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_we_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        trap_o,
  output logic [3:0]  trap_code_o,
  output logic [31:0] badaddr_o
);

  localparam int unsigned CW = (BUS_TIMEOUT != 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (BUS_TIMEOUT != 0) ? CW'(BUS_TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = CW'(BUS_TIMEOUT);

  lsu_state_e r_state, w_state_nxt;

  logic          r_killed;
  logic [CW-1:0] r_cnt;
  logic          r_cyc;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_addr;
  logic [31:0]   r_dat;
  logic [31:0]   r_ea;
  logic [2:0]    r_ld_f3;
  logic [1:0]    r_ld_off;
  logic [31:0]   r_rdata;
  logic          r_trap;
  logic [3:0]    r_trap_code;
  logic [31:0]   r_badaddr;

  logic [31:0] w_st_data;
  logic [3:0]  w_st_sel;
  logic        w_misalign;
  logic [31:0] w_ld_data;
  logic        w_req;
  logic        w_start;
  logic        w_mis_trap;
  logic        w_timeout;
  logic        w_fault;
  logic        w_end;
  logic        w_kill_any;

  lsu_align u_align (
    .i_st_funct3 (funct3_i),
    .i_st_off    (addr_i[1:0]),
    .i_st_wdata  (wdata_i),
    .o_st_data   (w_st_data),
    .o_st_sel    (w_st_sel),
    .o_misalign  (w_misalign),
    .i_ld_funct3 (r_ld_f3),
    .i_ld_off    (r_ld_off),
    .i_ld_word   (dwbm_dat_i),
    .o_ld_data   (w_ld_data)
  );

  assign w_req      = (r_state == ST_IDLE) && req_valid_i && !kill_i;
  assign w_start    = w_req && !w_misalign;
  // Gated by reset so every trap output reads zero while reset is held.
  assign w_mis_trap = w_req && w_misalign && !rst_i;
  assign w_timeout  = (BUS_TIMEOUT != 0) && (r_cnt == CNT_LAST);
  // err wins over ack; ack wins over a timeout expiring in the same cycle.
  assign w_fault    = dwbm_err_i || (w_timeout && !dwbm_ack_i);
  assign w_end      = dwbm_ack_i || dwbm_err_i || w_timeout;
  assign w_kill_any = r_killed || kill_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_BUSY;
          stall_o     = 1'b1;
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (w_end) w_state_nxt = w_kill_any ? ST_IDLE : ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_killed    <= 1'b0;
      r_cnt       <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_addr      <= '0;
      r_dat       <= '0;
      r_ea        <= '0;
      r_ld_f3     <= '0;
      r_ld_off    <= '0;
      r_rdata     <= '0;
      r_trap      <= 1'b0;
      r_trap_code <= '0;
      r_badaddr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cyc    <= 1'b1;
            r_we     <= is_store_i;
            r_sel    <= w_st_sel;
            r_addr   <= {addr_i[31:2], 2'b00};
            r_dat    <= is_store_i ? w_st_data : '0;
            r_ea     <= addr_i;
            r_ld_f3  <= funct3_i;
            r_ld_off <= addr_i[1:0];
            r_cnt    <= '0;
            r_killed <= 1'b0;
            r_trap   <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (kill_i) r_killed <= 1'b1;
          if ((BUS_TIMEOUT != 0) && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CW'(1);
          if (w_end) begin
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_killed <= 1'b0;
            if (w_fault) begin
              r_trap      <= !w_kill_any;
              r_trap_code <= r_we ? TRAP_ST_FAULT : TRAP_LD_FAULT;
              r_badaddr   <= r_ea;
            end else begin
              r_trap  <= 1'b0;
              r_rdata <= w_ld_data;
            end
          end
        end
        ST_DONE: r_trap <= 1'b0;
        default: ;
      endcase
    end
  end

  assign dwbm_addr_o = r_addr;
  assign dwbm_dat_o  = r_dat;
  assign dwbm_sel_o  = r_sel;
  assign dwbm_we_o   = r_we;
  assign dwbm_cyc_o  = r_cyc;
  assign dwbm_stb_o  = r_cyc;
  assign rdata_o     = r_rdata;

  assign trap_o      = w_mis_trap || ((r_state == ST_DONE) && r_trap && !kill_i);
  assign trap_code_o = w_mis_trap ? (is_store_i ? TRAP_ST_MISALIGN : TRAP_LD_MISALIGN)
                                  : r_trap_code;
  assign badaddr_o   = w_mis_trap ? addr_i : r_badaddr;

endmodule
